// File: rtl/multi_stream_gen.sv
// N-channel test-data source (counter / pattern / LFSR) merged round-robin into
// one show-ahead output register whose words carry the channel ID in the MSBs.
module multi_stream_gen #(
    parameter int CHANNELS = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 2,
    parameter logic [DATA_WIDTH-ID_WIDTH-1:0] LFSR_TAPS = 30'h20000029,
    parameter int BURST_WIDTH = 16
) (
    input  logic                                   BUS_CLK,
    input  logic                                   BUS_RST_N,
    input  logic [CHANNELS-1:0]                    EN,
    input  logic [CHANNELS-1:0]                    START,
    input  logic [2*CHANNELS-1:0]                  MODE,
    input  logic [CHANNELS*(DATA_WIDTH-ID_WIDTH)-1:0] PATTERN,
    input  logic [CHANNELS*BURST_WIDTH-1:0]        BURST,
    input  logic                                   READ,
    output logic                                   EMPTY,
    output logic [DATA_WIDTH-1:0]                  DATA,
    output logic [CHANNELS-1:0]                    BUSY,
    output logic                                   READ_ERROR,
    output logic [31:0]                            SENT_CNT
);
    localparam int PW = DATA_WIDTH - ID_WIDTH;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW:0] NCH = (CW+1)'(CHANNELS);
    localparam logic [1:0] M_PATTERN = 2'd1;
    localparam logic [1:0] M_LFSR = 2'd2;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

    ch_state_t               state_q[CHANNELS], state_d[CHANNELS];
    logic [1:0]              mode_q[CHANNELS], mode_d[CHANNELS];
    logic [PW-1:0]           payload_q[CHANNELS], payload_d[CHANNELS];
    logic [BURST_WIDTH-1:0]  remain_q[CHANNELS], remain_d[CHANNELS];
    logic [CHANNELS-1:0]     cont_q, cont_d;
    logic [CW-1:0]           ptr_q, gnt_idx;
    logic [CW:0]             cand;
    logic                    gnt_valid, can_load, pop;

    // Bit 0 of the tap mask is the polynomial's constant term, not a state tap.
    function automatic logic [PW-1:0] advance(input logic [1:0] mode, input logic [PW-1:0] v);
        logic fb;
        fb = ^(v & LFSR_TAPS & ~PW'(1));
        case (mode)
            M_PATTERN: advance = v;
            M_LFSR:    advance = {v[PW-2:0], fb};
            default:   advance = v + PW'(1);
        endcase
    endfunction

    assign can_load = EMPTY | READ;
    assign pop      = READ & ~EMPTY;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) BUSY[i] = (state_q[i] == RUN);
    end

    // Round-robin: search starts at ptr_q, which always points past the last grant.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            cand = {1'b0, ptr_q} + (CW+1)'(k);
            if (cand >= NCH) cand = cand - NCH;
            if (!gnt_valid && can_load && BUSY[cand[CW-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        cont_d = cont_q;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i]   = state_q[i];
            mode_d[i]    = mode_q[i];
            payload_d[i] = payload_q[i];
            remain_d[i]  = remain_q[i];
            case (state_q[i])
                IDLE: begin
                    if (START[i] && EN[i]) begin
                        state_d[i]  = RUN;
                        mode_d[i]   = MODE[2*i +: 2];
                        remain_d[i] = BURST[i*BURST_WIDTH +: BURST_WIDTH];
                        cont_d[i]   = (BURST[i*BURST_WIDTH +: BURST_WIDTH] == '0);
                        case (MODE[2*i +: 2])
                            M_PATTERN: payload_d[i] = PATTERN[i*PW +: PW];
                            M_LFSR:    payload_d[i] = (PATTERN[i*PW +: PW] == '0) ?
                                                      PW'(1) : PATTERN[i*PW +: PW];
                            default:   payload_d[i] = '0;
                        endcase
                    end
                end
                RUN: begin
                    if (gnt_valid && gnt_idx == CW'(i)) begin
                        payload_d[i] = advance(mode_q[i], payload_q[i]);
                        if (!cont_q[i]) begin
                            remain_d[i] = remain_q[i] - BURST_WIDTH'(1);
                            if (remain_q[i] == BURST_WIDTH'(1)) state_d[i] = IDLE;
                        end
                    end
                    if (!EN[i]) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= IDLE;
                mode_q[i]    <= '0;
                payload_q[i] <= '0;
                remain_q[i]  <= '0;
            end
            cont_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i]   <= state_d[i];
                mode_q[i]    <= mode_d[i];
                payload_q[i] <= payload_d[i];
                remain_q[i]  <= remain_d[i];
            end
            cont_q <= cont_d;
        end
    end

    // Output register: a grant implies it can load, so pop and refill share a cycle.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            EMPTY      <= 1'b1;
            DATA       <= '0;
            ptr_q      <= '0;
            READ_ERROR <= 1'b0;
            SENT_CNT   <= '0;
        end else begin
            if (gnt_valid) begin
                DATA  <= {ID_WIDTH'(gnt_idx), payload_q[gnt_idx]};
                EMPTY <= 1'b0;
                ptr_q <= (gnt_idx == CW'(CHANNELS-1)) ? '0 : gnt_idx + CW'(1);
            end else if (pop) begin
                EMPTY <= 1'b1;
            end
            if (READ && EMPTY) READ_ERROR <= 1'b1;
            if (pop && SENT_CNT != '1) SENT_CNT <= SENT_CNT + 32'd1;
        end
    end
endmodule

// File: tb/tb_multi_stream_gen.sv
// Self-checking bench for multi_stream_gen: expected words are queued when a
// channel is started and compared as the consumer pops them.
module tb_multi_stream_gen;
    logic         BUS_CLK = 1'b0;
    logic         BUS_RST_N = 1'b1;
    logic [3:0]   EN = '0;
    logic [3:0]   START = '0;
    logic [7:0]   MODE = '0;
    logic [119:0] PATTERN = '0;
    logic [63:0]  BURST = '0;
    logic         READ = 1'b0;
    logic         EMPTY;
    logic [31:0]  DATA;
    logic [3:0]   BUSY;
    logic         READ_ERROR;
    logic [31:0]  SENT_CNT;

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    multi_stream_gen dut (
        .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .EN(EN), .START(START),
        .MODE(MODE), .PATTERN(PATTERN), .BURST(BURST), .READ(READ),
        .EMPTY(EMPTY), .DATA(DATA), .BUSY(BUSY), .READ_ERROR(READ_ERROR),
        .SENT_CNT(SENT_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [29:0] lfsr_step(input logic [29:0] v);
        return {v[28:0], v[29] ^ v[5] ^ v[3]};
    endfunction

    task automatic set_ch(input int ch, input logic [1:0] m, input logic [29:0] pat,
                          input logic [15:0] b);
        MODE[2*ch +: 2]     = m;
        PATTERN[30*ch +: 30] = pat;
        BURST[16*ch +: 16]  = b;
    endtask

    task automatic do_reset();
        EN = '0; START = '0; MODE = '0; PATTERN = '0; BURST = '0; READ = 1'b0;
        exp_q.delete();
        BUS_RST_N = 1'b0;
        repeat (2) @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        @(negedge BUS_CLK);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", EMPTY); end
        n_cmp++; if (DATA !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", DATA); end
        n_cmp++; if (BUSY !== 4'h0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (READ_ERROR !== 1'b0) begin n_err++; $display("FAIL reset_rderr: got %b want 0", READ_ERROR); end
        n_cmp++; if (SENT_CNT !== 32'd0) begin n_err++; $display("FAIL reset_sent: got %0d want 0", SENT_CNT); end
    endtask

    task automatic test_counter_burst();
        logic [31:0] exp;
        bit started;
        do_reset();
        set_ch(0, 2'd0, 30'h0, 16'd4);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
        EN = 4'b0001; START = 4'b0001; READ = 1'b1;
        started = 0;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            START = '0;
            if (!EMPTY) begin
                started = 1;
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL burst_data: got %h want %h", DATA, exp); end
            end else if (started) begin
                n_cmp++; n_err++; $display("FAIL burst_gap: got EMPTY=1 want 0 mid-burst");
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL burst_timeout: got %0d left want 0", exp_q.size()); end
        @(negedge BUS_CLK);
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL burst_end_empty: got %b want 1", EMPTY); end
        n_cmp++; if (BUSY[0] !== 1'b0) begin n_err++; $display("FAIL burst_end_busy: got %b want 0", BUSY[0]); end
        n_cmp++; if (SENT_CNT !== 32'd4) begin n_err++; $display("FAIL burst_sent: got %0d want 4", SENT_CNT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        bit started;
        do_reset();
        set_ch(1, 2'd1, 30'h2BADCAFE, 16'd0);
        set_ch(2, 2'd0, 30'h0, 16'd0);
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'h6BADCAFE);
            exp_q.push_back({2'd2, 30'(k)});
        end
        EN = 4'b0110; START = 4'b0110; READ = 1'b1;
        started = 0;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            START = '0;
            if (!EMPTY) begin
                started = 1;
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL rr_data: got %h want %h", DATA, exp); end
            end else if (started) begin
                n_cmp++; n_err++; $display("FAIL rr_gap: got EMPTY=1 want 0");
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_timeout: got %0d left want 0", exp_q.size()); end
        EN = '0;
        repeat (4) @(negedge BUS_CLK);
        n_cmp++; if (BUSY !== 4'h0) begin n_err++; $display("FAIL rr_stop_busy: got %b want 0", BUSY); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL rr_stop_empty: got %b want 1", EMPTY); end
    endtask

    task automatic test_lfsr();
        logic [31:0] exp;
        logic [29:0] v;
        do_reset();
        set_ch(3, 2'd2, 30'h0, 16'd8);
        v = 30'h1;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back({2'd3, v});
            v = lfsr_step(v);
        end
        EN = 4'b1000; START = 4'b1000; READ = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            START = '0;
            if (!EMPTY) begin
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL lfsr_seed0: got %h want %h", DATA, exp); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lfsr_timeout: got %0d left want 0", exp_q.size()); end
        @(negedge BUS_CLK);
        set_ch(3, 2'd2, 30'h20000000, 16'd2);
        exp_q.push_back(32'hE0000000);
        exp_q.push_back(32'hC0000001);
        START = 4'b1000;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            START = '0;
            if (!EMPTY) begin
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL lfsr_tap29: got %h want %h", DATA, exp); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lfsr_tap_timeout: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp;
        do_reset();
        set_ch(0, 2'd0, 30'h0, 16'd3);
        for (int k = 0; k < 3; k++) exp_q.push_back(32'(k));
        EN = 4'b0001; START = 4'b0001;
        @(negedge BUS_CLK);
        START = '0;
        @(negedge BUS_CLK);
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (DATA !== exp_q[0] || EMPTY !== 1'b0 || BUSY[0] !== 1'b1) begin
                n_err++; $display("FAIL bp_hold: got data=%h empty=%b busy=%b want %h/0/1", DATA, EMPTY, BUSY[0], exp_q[0]);
            end
            if (c < 9) @(negedge BUS_CLK);
        end
        READ = 1'b1;
        void'(exp_q.pop_front());
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            if (!EMPTY) begin
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL bp_data: got %h want %h", DATA, exp); end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_timeout: got %0d left want 0", exp_q.size()); end
        for (int c = 0; c < 5; c++) begin
            @(negedge BUS_CLK);
            if (!EMPTY) begin n_cmp++; n_err++; $display("FAIL bp_extra: got word %h want none", DATA); end
        end
        n_cmp++; if (SENT_CNT !== 32'd3) begin n_err++; $display("FAIL bp_sent: got %0d want 3", SENT_CNT); end
        n_cmp++; if (BUSY[0] !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b want 0", BUSY[0]); end
    endtask

    task automatic test_en_drop();
        logic [31:0] exp;
        int extra;
        do_reset();
        set_ch(0, 2'd0, 30'h0, 16'd0);
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(k));
        EN = 4'b0001; START = 4'b0001; READ = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            START = '0;
            if (!EMPTY) begin
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL en_data: got %h want %h", DATA, exp); end
                if (exp_q.size() == 0) EN[0] = 1'b0;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL en_timeout: got %0d left want 0", exp_q.size()); end
        extra = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge BUS_CLK);
            if (!EMPTY) begin
                extra++;
                n_cmp++; if (DATA !== 32'd5) begin n_err++; $display("FAIL en_extra_data: got %h want 00000005", DATA); end
            end
        end
        n_cmp++; if (extra > 1) begin n_err++; $display("FAIL en_extra_count: got %0d want <=1", extra); end
        n_cmp++; if (BUSY[0] !== 1'b0) begin n_err++; $display("FAIL en_busy: got %b want 0", BUSY[0]); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL en_empty: got %b want 1", EMPTY); end
        START = 4'b0001;
        @(negedge BUS_CLK);
        START = '0;
        repeat (3) @(negedge BUS_CLK);
        n_cmp++; if (BUSY !== 4'h0 || EMPTY !== 1'b1) begin
            n_err++; $display("FAIL start_no_en: got busy=%b empty=%b want 0/1", BUSY, EMPTY);
        end
    endtask

    task automatic test_read_error_and_async_reset();
        logic [31:0] exp;
        do_reset();
        READ = 1'b1;
        @(negedge BUS_CLK);
        READ = 1'b0;
        n_cmp++; if (READ_ERROR !== 1'b1) begin n_err++; $display("FAIL rderr_set: got %b want 1", READ_ERROR); end
        n_cmp++; if (SENT_CNT !== 32'd0) begin n_err++; $display("FAIL rderr_sent: got %0d want 0", SENT_CNT); end
        n_cmp++; if (EMPTY !== 1'b1) begin n_err++; $display("FAIL rderr_empty: got %b want 1", EMPTY); end
        set_ch(0, 2'd0, 30'h0, 16'd8);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        EN = 4'b0001; START = 4'b0001; READ = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            @(negedge BUS_CLK);
            START = '0;
            if (!EMPTY) begin
                exp = exp_q.pop_front();
                n_cmp++; if (DATA !== exp) begin n_err++; $display("FAIL midrst_data: got %h want %h", DATA, exp); end
            end
        end
        n_cmp++; if (SENT_CNT !== 32'd1 || READ_ERROR !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: got sent=%0d rderr=%b want 1/1", SENT_CNT, READ_ERROR);
        end
        #2 BUS_RST_N = 1'b0;
        #1;
        n_cmp++; if (EMPTY !== 1'b1 || DATA !== 32'h0 || BUSY !== 4'h0 || READ_ERROR !== 1'b0 || SENT_CNT !== 32'd0) begin
            n_err++; $display("FAIL async_rst: got empty=%b data=%h busy=%b rderr=%b sent=%0d want 1/0/0/0/0",
                              EMPTY, DATA, BUSY, READ_ERROR, SENT_CNT);
        end
        EN = '0; START = '0; READ = 1'b0;
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        repeat (3) @(negedge BUS_CLK);
        n_cmp++; if (EMPTY !== 1'b1 || BUSY !== 4'h0 || DATA !== 32'h0) begin
            n_err++; $display("FAIL post_rst_idle: got empty=%b busy=%b data=%h want 1/0/0", EMPTY, BUSY, DATA);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_counter_burst();
        test_back_to_back();
        test_lfsr();
        test_backpressure();
        test_en_drop();
        test_read_error_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/multi_stream_gen.md
Name: multi_stream_gen

Overview:
Parametrised N-channel test-data source with a built-in round-robin merger and a single show-ahead FIFO-style output. It replaces a separate single counter source plus external arbiter for SRAM/USB readout tests. Each channel emits counter, fixed-pattern or LFSR words, either in bursts or continuously. Every output word is tagged with its channel ID. The output feeds the sram_fifo input port directly (DATA/EMPTY/READ).

Parameters:
CHANNELS, 4, number of generator channels (1..16)
DATA_WIDTH, 32, output word width
ID_WIDTH, 2, channel tag width in DATA MSBs; must be >= clog2(CHANNELS), min 1
LFSR_TAPS, 30'h20000029, Fibonacci tap mask over payload (PW = DATA_WIDTH-ID_WIDTH bits)
BURST_WIDTH, 16, width of per-channel burst length

Ports:
BUS_CLK  in  1  single clock, rising edge
BUS_RST_N  in  1  asynchronous active-low reset
EN  in  CHANNELS  per-channel enable, level
START  in  CHANNELS  per-channel start, sampled every cycle
MODE  in  2*CHANNELS  per channel: 0 counter, 1 pattern, 2 LFSR, 3 reserved (treated as counter)
PATTERN  in  CHANNELS*PW  per channel: pattern value / LFSR seed
BURST  in  CHANNELS*BURST_WIDTH  words per start; 0 = continuous
READ  in  1  consumer pop; valid only when EMPTY=0
EMPTY  out  1  output register holds no word
DATA  out  DATA_WIDTH  {channel ID, payload}; valid when EMPTY=0
BUSY  out  CHANNELS  channel in RUN
READ_ERROR  out  1  sticky: READ seen while EMPTY=1
SENT_CNT  out  32  words popped since reset, saturates at 2^32-1

Behaviour:
- Reset (async, BUS_RST_N=0): EMPTY=1, DATA=0, BUSY=0, READ_ERROR=0, SENT_CNT=0, all channels IDLE, round-robin pointer=0. Release is synchronous to BUS_CLK.
- Channel FSM IDLE->RUN: START[i]=1 and EN[i]=1 in IDLE. On that edge latch MODE, PATTERN, BURST. Payload init: counter 0; pattern PATTERN; LFSR PATTERN, or 1 if PATTERN=0.
- START[i] in RUN: ignored. START[i] with EN[i]=0: ignored.
- RUN->IDLE:
  - burst mode: on the grant of the last word (remaining count 1->0);
  - any mode: EN[i]=0 sampled. A grant in that same cycle is still completed.
- A channel in RUN requests every cycle.
- On grant, the payload is copied to the output register and then advances:
  - counter: +1 mod 2^PW;
  - pattern: unchanged;
  - LFSR: shift left by 1, LSB = XOR of bits selected by LFSR_TAPS.
- Output register:
  - Load when EMPTY=1, or when READ=1 in the same cycle (pop+refill gives 1 word/cycle throughput).
  - Load sets DATA={i[ID_WIDTH-1:0], payload} and EMPTY=0.
  - Pop with no requester: EMPTY=1; DATA holds last value.
- Arbitration: round-robin. Search starts at the channel after the last grant, wrapping CHANNELS-1->0. At most one grant per cycle. Grant only when the output register can load.
- Latency: START at edge t -> BUSY at t+1 -> earliest EMPTY=0 at t+2.
- READ while EMPTY=1: no state change except READ_ERROR=1 until reset.
- SENT_CNT increments on each READ with EMPTY=0 and saturates.
- A mid-burst reset drops all state; no partial word survives.
- Values in the output register are unaffected by later EN/START changes.

Test Plan:
1. Ch0 counter, BURST=4, START pulse, READ held 1 -> DATA = 0x00000000, 0x00000001, 0x00000002, 0x00000003 on consecutive cycles; then EMPTY=1, BUSY[0]=0, SENT_CNT=4.
2. Ch1 pattern 0x2BADCAFE, ch2 counter, both continuous, READ=1 -> IDs alternate 1,2,1,2. Ch1 words are 0x6BADCAFE; ch2 payloads are 0,1,2…; no cycle with EMPTY=1 after the first word.
3. Ch3 LFSR, seed 0 -> first payload 0x00000001, second 0x00000002; with seed 0x20000000 the second payload is 0x00000001 (tap bit 29 feeds back).
4. Backpressure: ch0 BURST=3, READ=0 for 10 cycles -> DATA stays 0x00000000, EMPTY=0, BUSY[0]=1. After READ resumes, exactly 3 words total are delivered.
5. Ch0 continuous, drop EN[0] after 5 pops -> at most one further word is delivered, then BUSY[0]=0 and EMPTY=1. A START pulse with EN=0 leaves the channel idle.
6. READ while EMPTY=1 -> READ_ERROR=1, SENT_CNT unchanged. Assert BUS_RST_N=0 mid-burst -> all outputs return to reset values immediately, without waiting for a clock edge.
